// File: rtl/lockstep_pair_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : lockstep_pair_ctrl_if
// Brief    : Dual-stream valid/ready bundle feeding the lockstep pair checker.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface lockstep_pair_ctrl_if #(
    parameter int LENGTH = 8
);
    logic [LENGTH-1:0] s1_data;
    logic              s1_valid;
    logic              s1_ready;
    logic [LENGTH-1:0] s2_data;
    logic              s2_valid;
    logic              s2_ready;

    modport master (
        output s1_data, s1_valid, s2_data, s2_valid,
        input  s1_ready, s2_ready
    );

    modport slave (
        input  s1_data, s1_valid, s2_data, s2_valid,
        output s1_ready, s2_ready
    );
endinterface

`default_nettype wire

// File: rtl/lockstep_pair_ctrl.sv
//------------------------------------------------------------------------------
// Module   : lockstep_pair_ctrl
// Brief    : Buffers two redundant streams and compares them pairwise, halting
//            on mismatches. Optional watchdog enabled by LOCKSTEP_TIMEOUT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lockstep_pair_ctrl #(
    parameter int LENGTH       = 8,
    parameter int DEPTH        = 4,
    parameter int MAX_MISMATCH = 1,
    parameter int TIMEOUT      = 64
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              enable,
    lockstep_pair_ctrl_if.slave    bus,
    input  wire logic              clear_err,
    output logic                   cmp_valid,
    output logic                   equal,
    output logic                   halted,
    output logic [15:0]            match_count,
    output logic [7:0]             mismatch_count,
    output logic [LENGTH-1:0]      err_data1,
    output logic [LENGTH-1:0]      err_data2,
    output logic                   timeout
);

    localparam int               C_PTR_W = $clog2(DEPTH);
    localparam logic [C_PTR_W:0] C_FULL  = (C_PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_pop;
    logic [1:0]        w_wr_valid;
    logic [1:0]        w_push;
    logic [1:0]        w_full;
    logic [1:0]        w_empty;
    logic [LENGTH-1:0] w_wr_data [2];
    logic [LENGTH-1:0] w_rd_data [2];
    logic              w_equal;
    logic [7:0]        w_mis_upd;
    logic              w_halt_mis;
    logic              w_wd_fire;

    logic              r_cmp_valid;
    logic              r_equal;
    logic [15:0]       r_match_count;
    logic [7:0]        r_mismatch_count;
    logic [LENGTH-1:0] r_err_data1;
    logic [LENGTH-1:0] r_err_data2;

    assign w_wr_data[0]  = bus.s1_data;
    assign w_wr_data[1]  = bus.s2_data;
    assign w_wr_valid[0] = bus.s1_valid;
    assign w_wr_valid[1] = bus.s2_valid;
    assign bus.s1_ready  = ~w_full[0];
    assign bus.s2_ready  = ~w_full[1];

    // Ready depends only on fullness, so a full FIFO opens one cycle after a pop.
    generate
        for (genvar s = 0; s < 2; s++) begin : g_fifo
            logic [LENGTH-1:0]  r_mem [DEPTH];
            logic [C_PTR_W-1:0] r_wr_ptr;
            logic [C_PTR_W-1:0] r_rd_ptr;
            logic [C_PTR_W:0]   r_count;

            assign w_full[s]    = (r_count == C_FULL);
            assign w_empty[s]   = (r_count == '0);
            assign w_push[s]    = w_wr_valid[s] & ~w_full[s];
            assign w_rd_data[s] = r_mem[r_rd_ptr];

            always_ff @(posedge clk) begin
                if (w_push[s]) begin
                    r_mem[r_wr_ptr] <= w_wr_data[s];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_push[s]) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end
                    if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                    case ({w_push[s], w_pop})
                        2'b10:   r_count <= r_count + 1'b1;
                        2'b01:   r_count <= r_count - 1'b1;
                        default: r_count <= r_count;
                    endcase
                end
            end
        end
    endgenerate

    assign w_equal    = (w_rd_data[0] == w_rd_data[1]);
    assign w_mis_upd  = (r_mismatch_count == 8'hFF) ? 8'hFF : r_mismatch_count + 8'd1;
    // Halt is decided from the popping cycle so the result and HALT land together.
    assign w_halt_mis = w_pop && !w_equal && (w_mis_upd >= 8'(MAX_MISMATCH));

`ifdef LOCKSTEP_TIMEOUT_EN
    localparam int C_WD_W = $clog2(TIMEOUT + 1);

    logic [C_WD_W-1:0] r_wd_count;
    logic              r_timeout;
    logic              w_wd_qual;

    assign w_wd_qual = (r_state == RUN) && (w_empty[0] != w_empty[1]);
    assign w_wd_fire = w_wd_qual && (r_wd_count == C_WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_count <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_wd_count <= (w_wd_qual && !w_wd_fire) ? r_wd_count + 1'b1 : '0;
            if (w_wd_fire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_wd_fire = 1'b0;
    assign timeout   = 1'b0;

    // TIMEOUT has no effect when the watchdog is compiled out.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_pop = !w_empty[0] && !w_empty[1];
                if (w_halt_mis || w_wd_fire) begin
                    w_state_nxt = HALT;
                end else if (!enable) begin
                    w_state_nxt = IDLE;
                end
            end
            HALT: begin
                if (clear_err) begin
                    w_state_nxt = enable ? RUN : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmp_valid      <= 1'b0;
            r_equal          <= 1'b1;
            r_match_count    <= '0;
            r_mismatch_count <= '0;
            r_err_data1      <= '0;
            r_err_data2      <= '0;
        end else begin
            r_cmp_valid <= w_pop;
            if (w_pop) begin
                r_equal <= w_equal;
                if (w_equal) begin
                    if (r_match_count != 16'hFFFF) begin
                        r_match_count <= r_match_count + 16'd1;
                    end
                end else begin
                    r_err_data1 <= w_rd_data[0];
                    r_err_data2 <= w_rd_data[1];
                end
            end
            if ((r_state == HALT) && clear_err) begin
                r_mismatch_count <= '0;
            end else if (w_pop && !w_equal) begin
                r_mismatch_count <= w_mis_upd;
            end
        end
    end

    assign cmp_valid      = r_cmp_valid;
    assign equal          = r_equal;
    assign halted         = (r_state == HALT);
    assign match_count    = r_match_count;
    assign mismatch_count = r_mismatch_count;
    assign err_data1      = r_err_data1;
    assign err_data2      = r_err_data2;

endmodule

`default_nettype wire

// File: tb/tb_lockstep_pair_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_lockstep_pair_ctrl
// Brief    : Directed self-checking bench for lockstep_pair_ctrl; the watchdog
//            scenario is included when LOCKSTEP_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lockstep_pair_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        clear_err = 1'b0;
    logic        cmp_valid, equal, halted, timeout;
    logic [15:0] match_count;
    logic [7:0]  mismatch_count, err_data1, err_data2;

    logic        en3 = 1'b0;
    logic        clr3 = 1'b0;
    logic        cmp_valid3, equal3, halted3, timeout3;
    logic [15:0] match_count3;
    logic [7:0]  mismatch_count3, err3_data1, err3_data2;

    int n_assert = 0;
    int n_fail   = 0;

    lockstep_pair_ctrl_if #(.LENGTH(8)) bus  ();
    lockstep_pair_ctrl_if #(.LENGTH(8)) bus3 ();

    lockstep_pair_ctrl #(.LENGTH(8), .DEPTH(4), .MAX_MISMATCH(1), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .bus(bus), .clear_err(clear_err),
        .cmp_valid(cmp_valid), .equal(equal), .halted(halted),
        .match_count(match_count), .mismatch_count(mismatch_count),
        .err_data1(err_data1), .err_data2(err_data2), .timeout(timeout)
    );

    lockstep_pair_ctrl #(.LENGTH(8), .DEPTH(4), .MAX_MISMATCH(3), .TIMEOUT(64)) dut3 (
        .clk(clk), .rst(rst), .enable(en3), .bus(bus3), .clear_err(clr3),
        .cmp_valid(cmp_valid3), .equal(equal3), .halted(halted3),
        .match_count(match_count3), .mismatch_count(mismatch_count3),
        .err_data1(err3_data1), .err_data2(err3_data2), .timeout(timeout3)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic seen_cv;

    initial begin
        bus.s1_data = '0;  bus.s1_valid = 1'b0;  bus.s2_data = '0;  bus.s2_valid = 1'b0;
        bus3.s1_data = '0; bus3.s1_valid = 1'b0; bus3.s2_data = '0; bus3.s2_valid = 1'b0;

        // Reset state
        step(); step();
        rst = 1'b0;
        check("rst_cmp_valid", cmp_valid, 0);
        check("rst_equal", equal, 1);
        check("rst_halted", halted, 0);
        check("rst_match", match_count, 0);
        check("rst_mismatch", mismatch_count, 0);
        check("rst_err1", err_data1, 0);
        check("rst_err2", err_data2, 0);
        check("rst_timeout", timeout, 0);
        check("rst_s1_ready", bus.s1_ready, 1);
        check("rst_s2_ready", bus.s2_ready, 1);

        // Two matching pairs
        enable = 1'b1;
        step();
        bus.s1_data = 8'h11; bus.s2_data = 8'h11; bus.s1_valid = 1'b1; bus.s2_valid = 1'b1;
        step();
        bus.s1_data = 8'h22; bus.s2_data = 8'h22;
        step();
        check("m1_cmp_valid", cmp_valid, 1);
        check("m1_equal", equal, 1);
        check("m1_match", match_count, 1);
        bus.s1_valid = 1'b0; bus.s2_valid = 1'b0;
        step();
        check("m2_cmp_valid", cmp_valid, 1);
        check("m2_equal", equal, 1);
        check("m2_match", match_count, 2);
        step();
        check("m_idle_cmp_valid", cmp_valid, 0);
        check("m_mismatch", mismatch_count, 0);

        // Mismatch halts; a following matched pair waits for clear_err
        bus.s1_data = 8'h05; bus.s2_data = 8'h06; bus.s1_valid = 1'b1; bus.s2_valid = 1'b1;
        step();
        bus.s1_valid = 1'b0; bus.s2_valid = 1'b0;
        step();
        check("mm_cmp_valid", cmp_valid, 1);
        check("mm_equal", equal, 0);
        check("mm_err1", err_data1, 8'h05);
        check("mm_err2", err_data2, 8'h06);
        check("mm_count", mismatch_count, 1);
        check("mm_halted", halted, 1);
        bus.s1_data = 8'h33; bus.s2_data = 8'h33; bus.s1_valid = 1'b1; bus.s2_valid = 1'b1;
        step();
        bus.s1_valid = 1'b0; bus.s2_valid = 1'b0;
        step(); step();
        check("halt_no_pop_cv", cmp_valid, 0);
        check("halt_no_pop_match", match_count, 2);
        check("halt_still", halted, 1);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        check("clr_halted", halted, 0);
        check("clr_mismatch", mismatch_count, 0);
        check("clr_err1_hold", err_data1, 8'h05);
        step();
        check("clr_pop_cv", cmp_valid, 1);
        check("clr_pop_equal", equal, 1);
        check("clr_pop_match", match_count, 3);

        // Fill both FIFOs while idle, then drain back to back
        enable = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            bus.s1_data = 8'hA0 + 8'(i); bus.s2_data = 8'hA0 + 8'(i);
            bus.s1_valid = 1'b1; bus.s2_valid = 1'b1;
            step();
        end
        bus.s1_valid = 1'b0; bus.s2_valid = 1'b0;
        check("full_s1_ready", bus.s1_ready, 0);
        check("full_s2_ready", bus.s2_ready, 0);
        check("full_idle_cv", cmp_valid, 0);
        enable = 1'b1;
        step();
        check("run_entry_s1_ready", bus.s1_ready, 0);
        step();
        check("drain0_cv", cmp_valid, 1);
        check("drain0_s1_ready", bus.s1_ready, 1);
        check("drain0_s2_ready", bus.s2_ready, 1);
        for (int i = 1; i < 4; i++) begin
            step();
            check("drain_cv", cmp_valid, 1);
        end
        check("drain_equal", equal, 1);
        step();
        check("drain_done_cv", cmp_valid, 0);
        check("drain_match", match_count, 7);

        // Reset in the middle of a stream-1 burst
        bus.s1_valid = 1'b1; bus.s1_data = 8'h40;
        step();
        bus.s1_data = 8'h41;
        step();
        bus.s1_data = 8'h42; rst = 1'b1;
        step();
        rst = 1'b0; bus.s1_valid = 1'b0;
        check("mrst_match", match_count, 0);
        check("mrst_mismatch", mismatch_count, 0);
        check("mrst_cv", cmp_valid, 0);
        check("mrst_s1_ready", bus.s1_ready, 1);
        bus.s2_valid = 1'b1; bus.s2_data = 8'h40;
        step();
        bus.s2_valid = 1'b0;
        seen_cv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen_cv = seen_cv | cmp_valid;
        end
        check("mrst_no_result", seen_cv, 0);
        check("mrst_timeout", timeout, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;

`ifdef LOCKSTEP_TIMEOUT_EN
        // One-sided traffic trips the watchdog after 8 RUN cycles
        step();
        bus.s1_valid = 1'b1; bus.s1_data = 8'h77;
        step();
        bus.s1_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("wd_before_timeout", timeout, 0);
        check("wd_before_halted", halted, 0);
        step();
        check("wd_timeout", timeout, 1);
        check("wd_halted", halted, 1);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        check("wd_clr_halted", halted, 0);
        check("wd_clr_sticky", timeout, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
`endif

        // Second instance: repeated mismatch bursts, then saturating match flood
        en3 = 1'b1;
        step();
        for (int k = 0; k < 100; k++) begin
            for (int j = 0; j < 3; j++) begin
                bus3.s1_data = 8'(3 * k + j);
                bus3.s2_data = ~8'(3 * k + j);
                bus3.s1_valid = 1'b1; bus3.s2_valid = 1'b1;
                step();
            end
            bus3.s1_valid = 1'b0; bus3.s2_valid = 1'b0;
            step();
            check("m3_halted", halted3, 1);
            check("m3_mismatch", mismatch_count3, 3);
            clr3 = 1'b1;
            step();
            clr3 = 1'b0;
            check("m3_cleared", mismatch_count3, 0);
        end
        check("m3_no_match", match_count3, 0);
        bus3.s1_data = 8'h5A; bus3.s2_data = 8'h5A;
        bus3.s1_valid = 1'b1; bus3.s2_valid = 1'b1;
        for (int i = 0; i < 70000; i++) step();
        bus3.s1_valid = 1'b0; bus3.s2_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("sat_match", match_count3, 16'hFFFF);
        check("sat_mismatch", mismatch_count3, 0);
        check("sat_halted", halted3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lockstep_pair_ctrl.md
LOCKSTEP_PAIR_CTRL -- requirements
Module: lockstep_pair_ctrl

Interface
REQ-001 Parameter LENGTH, default 8, width of each stream data word.
REQ-002 Parameter DEPTH, default 4, per-stream FIFO entries, power of two, minimum 2.
REQ-003 Parameter MAX_MISMATCH, default 1, mismatch count that halts pairing; range 1..255.
REQ-004 Parameter TIMEOUT, default 64, watchdog limit in cycles; used only under LOCKSTEP_TIMEOUT_EN.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 enable  in  1  permits pairing; when low, FSM holds in IDLE.
REQ-008 s1_data  in  LENGTH  stream-1 word.
REQ-009 s1_valid  in  1  stream-1 word offered.
REQ-010 s1_ready  out  1  stream-1 word accepted when s1_valid and s1_ready are both high.
REQ-011 s2_data, s2_valid, s2_ready  same widths and directions as the stream-1 ports  stream-2 equivalents.
REQ-012 clear_err  in  1  single-cycle pulse; leaves HALT and zeroes mismatch_count.
REQ-013 cmp_valid  out  1  one-cycle pulse, one comparison result available.
REQ-014 equal  out  1  result of the last comparison; holds between pulses.
REQ-015 halted  out  1  high while in HALT.
REQ-016 match_count  out  16  number of equal pairs, saturating.
REQ-017 mismatch_count  out  8  number of unequal pairs, saturating.
REQ-018 err_data1, err_data2  out  LENGTH each  operands of the most recent mismatch.
REQ-019 timeout  out  1  sticky watchdog flag; tied 0 without LOCKSTEP_TIMEOUT_EN.

Function
REQ-020 Each stream SHALL feed its own DEPTH-entry FIFO; sN_ready = !fullN, and this holds in every state.
REQ-021 FSM states SHALL be IDLE, RUN and HALT.
REQ-022 IDLE->RUN when enable=1; RUN->IDLE when enable=0; a RUN->IDLE transition SHALL keep FIFO contents.
REQ-023 In RUN, when both FIFOs are non-empty, one word SHALL be popped from each FIFO in the same cycle; no pop in IDLE or HALT.
REQ-024 A pop in cycle N SHALL produce cmp_valid=1 in cycle N+1, with equal = (word1 == word2) from the popped pair; throughput is one pair per cycle.
REQ-025 A push and a pop on the same FIFO in the same cycle SHALL both take effect; occupancy is unchanged. Pointers wrap modulo DEPTH.
REQ-026 A mismatch SHALL increment mismatch_count and capture err_data1 and err_data2 in cycle N+1.
REQ-027 A match SHALL increment match_count in cycle N+1. Both counters saturate, at 0xFFFF and 0xFF respectively.
REQ-028 RUN->HALT in cycle N+1 when the updated mismatch_count >= MAX_MISMATCH; no pop occurs in that cycle or afterwards while in HALT.
REQ-029 In HALT, clear_err=1 SHALL go to RUN if enable=1, otherwise to IDLE, and SHALL zero mismatch_count. clear_err SHALL be ignored in other states.
REQ-030 A result produced on the same edge as a clear_err SHALL still be counted; clear_err takes priority only on mismatch_count.

Reset
REQ-031 rst SHALL flush both FIFOs and set state=IDLE.
REQ-032 rst SHALL set cmp_valid=0, equal=1, halted=0, both counts=0, err_data1=err_data2=0 and timeout=0; sN_ready=1 in the following cycle.
REQ-033 rst asserted mid-operation SHALL discard any in-flight comparison result.

Configuration
REQ-034 With LOCKSTEP_TIMEOUT_EN defined, a counter SHALL count RUN cycles in which exactly one FIFO is non-empty, and clear on any other cycle.
REQ-035 When that counter reaches TIMEOUT, timeout SHALL set (sticky until rst) and the FSM SHALL enter HALT; clear_err leaves HALT but does not clear timeout.
REQ-036 Without LOCKSTEP_TIMEOUT_EN, no watchdog logic SHALL exist and timeout SHALL be tied 0.

Verification
REQ-037 Push 0x11, 0x22 on both streams with enable=1 -> two cmp_valid pulses with equal=1; match_count=2, mismatch_count=0.
REQ-038 s1=0x05, s2=0x06 -> equal=0, err_data1=0x05, err_data2=0x06, mismatch_count=1, halted=1; a following matched pair is not popped until clear_err.
REQ-039 enable=0, push 4 words per stream -> s1_ready=s2_ready=0; raise enable -> 4 results on consecutive cycles, and ready rises the cycle after the first pop.
REQ-040 Push 3 words on stream 1 only, then assert rst mid-burst -> FIFOs empty, counts 0, no cmp_valid pulse afterwards.
REQ-041 LOCKSTEP_TIMEOUT_EN with TIMEOUT=8, one word on stream 1 only -> timeout=1 and halted=1 after 8 RUN cycles.
REQ-042 MAX_MISMATCH=3 with 300 mismatching pairs under repeated clear_err, plus 70000 matching pairs -> mismatch_count never exceeds 0xFF, match_count saturates at 0xFFFF.
